wb_iccm_loader: RTL and testbench
=================================

// Module: wb_iccm_loader
// PURPOSE
//   Wishbone-slave alternative to the UART programming path. Lets the management SoC
//   hold the core in reset, stream instruction words into the instruction DFFRAM,
//   then release the core. Its outputs drive the same instr-RAM program port and core
//   reset that the UART loader drives; the top-level mux selects between the two.
// PARAMETERS
//   BASE_ADDR  32'h3000_0000  Wishbone base address; decoded on wbs_adr_i[31:4].
//   AW         14             Instruction word-address width of addr_o.
// PORTS
//   wb_clk_i   in   1   Single clock; all logic is on its rising edge.
//   wb_rst_i   in   1   Reset, asynchronous assert, active-high.
//   wbs_stb_i  in   1   Wishbone strobe.
//   wbs_cyc_i  in   1   Wishbone cycle.
//   wbs_we_i   in   1   1 = write, 0 = read.
//   wbs_sel_i  in   4   Byte selects.
//   wbs_adr_i  in   32  Byte address. [3:2]: 0 CTRL, 1 ADDR, 2 DATA, 3 STATUS.
//   wbs_dat_i  in   32  Write data.
//   wbs_ack_o  out  1   Acknowledge; one-cycle pulse.
//   wbs_dat_o  out  32  Read data; valid only while wbs_ack_o = 1, 0 otherwise.
//   we_o       out  4   Per-byte write enables to instr RAM (copy of wbs_sel_i).
//   addr_o     out  AW  Instr RAM word address.
//   wdata_o    out  32  Instr RAM write data.
//   reset_o    out  1   Active-low core reset (= ~CTRL.hold).
// BEHAVIOUR
//   Reset: FSM=IDLE. wbs_ack_o=0, wbs_dat_o=0, we_o=0, addr_o=0, wdata_o=0.
//     CTRL.hold=1, so reset_o=0 and the core is held. ADDR=0, COUNT=0, ERR=0.
//   Decode: hit = stb & cyc & (wbs_adr_i[31:4] == BASE_ADDR[31:4]).
//     A miss is never acked.
//   FSM IDLE -> ACK on hit; the request is sampled on that edge. ACK -> IDLE unconditionally.
//   In ACK, wbs_ack_o=1 for exactly one cycle; the hit-to-ack latency is 1 cycle.
//     The master drops stb after the ack. A hit still present in IDLE is a new request.
//   Registers:
//     CTRL   [0] hold (RW).
//            [1] clr_cnt: write 1 clears COUNT. Self-clearing; reads back 0.
//     ADDR   [AW-1:0] next word address (RW). Bits above AW read 0.
//     DATA   Write: a program write. Read: the last word written to DATA.
//     STATUS [15:0] COUNT, RO.
//            [16] ERR: sticky; W1C.
//            [17] hold mirror, RO.
//   Register writes (CTRL, ADDR, STATUS W1C) take effect on the edge ending the ACK cycle.
//     They apply only to bytes with wbs_sel_i set.
//   Program write (DATA write with hold=1):
//     In the ACK cycle: we_o=wbs_sel_i, addr_o=ADDR, wdata_o=wbs_dat_i.
//     At the end of that cycle: ADDR <= ADDR+1, wrapping 2^AW-1 -> 0.
//     COUNT <= COUNT+1, saturating at 16'hFFFF.
//   we_o is 0 in every other cycle. addr_o and wdata_o hold their last values.
//   DATA write with hold=0: ignored, no we_o pulse, ERR <= 1. The write is still acked.
//   DATA write with sel=0: acked, no we_o pulse, ADDR and COUNT unchanged.
//   One write setting both CTRL.hold=0 and clr_cnt: both take effect.
//   reset_o follows CTRL.hold combinationally from the register (no extra delay).
//   Reset mid-operation: an in-flight ACK is dropped, we_o returns to 0 immediately,
//     all state is re-initialised, and the core is held again.
//   Reads return the register value at the time of the ACK cycle.
// TESTING
//   1. Reset, read STATUS -> 0x0002_0000; reset_o=0.
//      Read from BASE+0x40 (miss) -> no ack within 8 cycles.
//   2. Write ADDR=0x0010, then DATA 0xDEADBEEF and 0x12345678, sel=4'hF
//      -> we_o=4'hF pulses at addr_o 0x10 and 0x11 with matching wdata_o.
//      STATUS COUNT=2; ADDR reads 0x12.
//   3. ADDR=0x3FFF, DATA write -> addr_o=0x3FFF; ADDR then reads 0x0000 (wrap).
//   4. CTRL=0 (reset_o=1), then DATA write -> acked, we_o stays 0, STATUS[16]=1.
//      Write STATUS 0x0001_0000 -> ERR=0.
//   5. DATA write with sel=4'b0101 -> we_o=4'b0101.
//      Then CTRL=0x2 -> COUNT=0 and hold=0.
//   6. Assert wb_rst_i during a DATA ACK cycle -> ack and we_o drop in the same cycle.
//      ADDR=0; reset_o=0.

Source files
------------

// File: rtl/wb_iccm_loader.sv
// Wishbone slave that holds the core in reset and streams words into the instruction RAM.
// One-cycle hit-to-ack latency. No backpressure: every decoded hit is acked one cycle later.
module wb_iccm_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          AW        = 14
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_adr_i,
    input  logic [31:0]   wbs_dat_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    output logic [3:0]    we_o,
    output logic [AW-1:0] addr_o,
    output logic [31:0]   wdata_o,
    output logic          reset_o
);

    typedef enum logic {IDLE, ACK} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_ADDR   = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    state_t        state_q, state_d;
    logic          req_we_q, req_we_d;
    logic [3:0]    req_sel_q, req_sel_d;
    logic [1:0]    req_reg_q, req_reg_d;
    logic [31:0]   req_dat_q, req_dat_d;
    logic          hold_q, hold_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [31:0]   data_q, data_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic [31:0]   last_wdata_q, last_wdata_d;

    logic          hit;
    logic          ack;
    logic          prog_wr;
    logic [31:0]   rdata;
    logic          unused_adr;

    assign hit        = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign unused_adr = ^wbs_adr_i[1:0];

    always_comb begin
        state_d      = state_q;
        req_we_d     = req_we_q;
        req_sel_d    = req_sel_q;
        req_reg_d    = req_reg_q;
        req_dat_d    = req_dat_q;
        hold_d       = hold_q;
        addr_d       = addr_q;
        count_d      = count_q;
        err_d        = err_q;
        data_d       = data_q;
        last_addr_d  = last_addr_q;
        last_wdata_d = last_wdata_q;
        ack          = 1'b0;
        prog_wr      = 1'b0;
        rdata        = 32'h0;

        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d   = ACK;
                    req_we_d  = wbs_we_i;
                    req_sel_d = wbs_sel_i;
                    req_reg_d = wbs_adr_i[3:2];
                    req_dat_d = wbs_dat_i;
                end
            end
            ACK: begin
                state_d = IDLE;
                ack     = 1'b1;
                case (req_reg_q)
                    REG_CTRL:   rdata = {31'h0, hold_q};
                    REG_ADDR:   rdata = {{(32-AW){1'b0}}, addr_q};
                    REG_DATA:   rdata = data_q;
                    REG_STATUS: rdata = {14'h0, hold_q, err_q, count_q};
                    default:    rdata = 32'h0;
                endcase
                if (req_we_q) begin
                    case (req_reg_q)
                        REG_CTRL: begin
                            if (req_sel_q[0]) begin
                                hold_d = req_dat_q[0];
                                if (req_dat_q[1]) count_d = 16'h0;
                            end
                        end
                        REG_ADDR: begin
                            for (int i = 0; i < AW; i++) begin
                                if (req_sel_q[i/8]) addr_d[i] = req_dat_q[i];
                            end
                        end
                        REG_DATA: begin
                            if (!hold_q) begin
                                err_d = 1'b1;
                            end else if (req_sel_q != 4'h0) begin
                                prog_wr      = 1'b1;
                                addr_d       = addr_q + 1'b1;
                                count_d      = (count_q == 16'hFFFF) ? count_q : count_q + 16'h1;
                                last_addr_d  = addr_q;
                                last_wdata_d = req_dat_q;
                                for (int b = 0; b < 4; b++) begin
                                    if (req_sel_q[b]) data_d[b*8 +: 8] = req_dat_q[b*8 +: 8];
                                end
                            end
                        end
                        REG_STATUS: begin
                            if (req_sel_q[2] && req_dat_q[16]) err_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from async-reset state, so reset drops ack/we_o at once.
    assign wbs_ack_o = ack;
    assign wbs_dat_o = rdata;
    assign we_o      = prog_wr ? req_sel_q : 4'h0;
    assign addr_o    = prog_wr ? addr_q : last_addr_q;
    assign wdata_o   = prog_wr ? req_dat_q : last_wdata_q;
    assign reset_o   = ~hold_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_sel_q    <= 4'h0;
            req_reg_q    <= 2'd0;
            req_dat_q    <= 32'h0;
            hold_q       <= 1'b1;
            addr_q       <= '0;
            count_q      <= 16'h0;
            err_q        <= 1'b0;
            data_q       <= 32'h0;
            last_addr_q  <= '0;
            last_wdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_we_q     <= req_we_d;
            req_sel_q    <= req_sel_d;
            req_reg_q    <= req_reg_d;
            req_dat_q    <= req_dat_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            data_q       <= data_d;
            last_addr_q  <= last_addr_d;
            last_wdata_q <= last_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_iccm_loader.sv
// Randomized bench for wb_iccm_loader against a register-level reference model.
module tb_wb_iccm_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          AW   = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          stb, cyc, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_i;
    logic          ack;
    logic [31:0]   dat_o;
    logic [3:0]    we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          reset_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    bit        m_hold;
    int        m_addr, m_count, m_last_addr;
    bit        m_err;
    logic [31:0] m_data, m_last_wdata;

    wb_iccm_loader #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(dat_i),
        .wbs_ack_o(ack),
        .wbs_dat_o(dat_o),
        .we_o     (we_o),
        .addr_o   (addr_o),
        .wdata_o  (wdata_o),
        .reset_o  (reset_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hold = 1; m_addr = 0; m_count = 0; m_err = 0;
        m_data = 0; m_last_addr = 0; m_last_wdata = 0;
    endtask

    function automatic logic [31:0] model_read(input int r);
        case (r)
            0:       return {31'h0, m_hold};
            1:       return m_addr;
            2:       return m_data;
            default: return {14'h0, m_hold, m_err, m_count[15:0]};
        endcase
    endfunction

    // One bus transaction; waits at most 8 cycles for the ack.
    task automatic bus(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                       output bit acked, output logic [31:0] rd, output logic [3:0] we_seen,
                       output logic [31:0] a_seen, output logic [31:0] wd_seen);
        @(negedge clk);
        stb = 1; cyc = 1; we = w; adr = a; sel = s; dat_i = d;
        acked = 0; rd = 0; we_seen = 0; a_seen = 0; wd_seen = 0;
        for (int i = 0; i < 8 && !acked; i++) begin
            @(negedge clk);
            if (ack) begin
                acked = 1; rd = dat_o; we_seen = we_o; a_seen = addr_o; wd_seen = wdata_o;
            end
        end
        stb = 0; cyc = 0; we = 0;
    endtask

    task automatic after_txn();
        @(negedge clk);
        chk("idle_ack", ack, 0);
        chk("idle_we", we_o, 0);
        chk("reset_o", reset_o, !m_hold);
        chk("hold_addr_o", addr_o, m_last_addr);
        chk("hold_wdata_o", wdata_o, m_last_wdata);
    endtask

    task automatic do_write(input int r, input logic [3:0] s, input logic [31:0] d);
        bit acked; logic [31:0] rd; logic [3:0] ws; logic [31:0] as, wds;
        bit prog;
        int na;
        prog = (r == 2) && m_hold && (s != 0);
        bus(1, BASE + r * 4, s, d, acked, rd, ws, as, wds);
        chk("wr_ack", acked, 1);
        chk("wr_we_o", ws, prog ? s : 4'h0);
        if (prog) begin
            chk("wr_addr_o", as, m_addr);
            chk("wr_wdata_o", wds, d);
        end
        case (r)
            0: if (s[0]) begin
                   m_hold = d[0];
                   if (d[1]) m_count = 0;
               end
            1: begin
                   na = m_addr;
                   if (s[0]) na = (na & 32'h3F00) | (d & 32'hFF);
                   if (s[1]) na = (na & 32'h00FF) | (d & 32'h3F00);
                   m_addr = na;
               end
            2: if (!m_hold) m_err = 1;
               else if (s != 0) begin
                   for (int b = 0; b < 4; b++) if (s[b]) m_data[b*8 +: 8] = d[b*8 +: 8];
                   m_last_addr  = m_addr;
                   m_last_wdata = d;
                   m_addr  = (m_addr + 1) % (1 << AW);
                   m_count = (m_count == 65535) ? 65535 : m_count + 1;
               end
            default: if (s[2] && d[16]) m_err = 0;
        endcase
        after_txn();
    endtask

    task automatic do_read(input int r, output logic [31:0] rd);
        bit acked; logic [3:0] ws; logic [31:0] as, wds;
        logic [31:0] exp;
        exp = model_read(r);
        bus(0, BASE + r * 4, 4'hF, $urandom, acked, rd, ws, as, wds);
        chk("rd_ack", acked, 1);
        chk($sformatf("rd_reg%0d", r), rd, exp);
        chk("rd_we_o", ws, 0);
        after_txn();
    endtask

    initial begin
        logic [31:0] rd, d;
        bit acked; logic [3:0] ws, s; logic [31:0] as, wds;
        int r;

        rst = 1; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat_o", dat_o, 0);
        chk("rst_we_o", we_o, 0);
        chk("rst_addr_o", addr_o, 0);
        chk("rst_wdata_o", wdata_o, 0);
        chk("rst_reset_o", reset_o, 0);
        rst = 0;

        // 1: status after reset, miss never acked
        do_read(3, rd);
        chk("t1_status", rd, 32'h0002_0000);
        bus(0, BASE + 32'h40, 4'hF, 0, acked, rd, ws, as, wds);
        chk("t1_miss_noack", acked, 0);

        // 2: two program writes from 0x10
        do_write(1, 4'hF, 32'h10);
        do_write(2, 4'hF, 32'hDEADBEEF);
        do_write(2, 4'hF, 32'h12345678);
        do_read(3, rd);
        chk("t2_count", rd, 32'h0002_0002);
        do_read(1, rd);
        chk("t2_addr", rd, 32'h12);
        do_read(2, rd);
        chk("t2_data", rd, 32'h12345678);

        // 3: address wrap
        do_write(1, 4'hF, 32'h3FFF);
        do_write(2, 4'hF, 32'hA5A5_0001);
        do_read(1, rd);
        chk("t3_wrap", rd, 0);

        // 4: write without hold sets ERR, W1C clears it
        do_write(0, 4'hF, 0);
        chk("t4_reset_o", reset_o, 1);
        do_write(2, 4'hF, 32'hCAFE_F00D);
        do_read(3, rd);
        chk("t4_err", rd[16], 1);
        do_write(3, 4'hF, 32'h0001_0000);
        do_read(3, rd);
        chk("t4_err_clr", rd[16], 0);

        // 5: partial byte enables, then clr_cnt together with hold=0
        do_write(0, 4'hF, 1);
        do_write(2, 4'b0101, 32'h1122_3344);
        do_write(2, 4'b0000, 32'hFFFF_FFFF);
        do_write(0, 4'hF, 2);
        do_read(3, rd);
        chk("t5_status", rd, 0);
        do_write(0, 4'hF, 1);

        // Randomized mix against the model
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(3);
            s = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
            d = $urandom;
            if (r == 0) begin
                d[0] = ($urandom_range(3) != 0);
                d[1] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(1) == 1) do_write(r, s, d);
            else do_read(r, rd);
            repeat ($urandom_range(2)) @(negedge clk);
        end

        // 6: reset during a program-write ack
        do_write(0, 4'hF, 1);
        do_write(1, 4'hF, 32'h55);
        @(negedge clk);
        stb = 1; cyc = 1; we = 1; adr = BASE + 8; sel = 4'hF; dat_i = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        chk("t6_ack_before", ack, 1);
        chk("t6_we_before", we_o, 4'hF);
        rst = 1;
        #1;
        chk("t6_ack_drop", ack, 0);
        chk("t6_we_drop", we_o, 0);
        chk("t6_reset_o", reset_o, 0);
        @(negedge clk);
        stb = 0; cyc = 0; we = 0;
        rst = 0;
        model_reset();
        do_read(1, rd);
        chk("t6_addr", rd, 0);
        do_read(3, rd);
        chk("t6_status", rd, 32'h0002_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
